mac_seq_multiply: RTL and testbench

Parametrised iterative multiplier for the MAC datapath and the next generation of the single-cycle array multiply stage. It computes the full-width product of two MAC_MIN_WIDTH operands over a configurable number of cycles, retiring BITS_PER_CYCLE multiplier bits per cycle. It supports signed or unsigned operands per transaction and uses valid/ready handshakes on both sides, so it sits between the MAC operand registers and the accumulate stage with back-pressure.

---
 rtl/mac_seq_multiply.sv | 106 ++++++++++
 tb/tb_mac_seq_multiply.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_multiply.sv
// Iterative sign/magnitude multiplier: retires BITS_PER_CYCLE multiplier bits per RUN cycle.
// Latency: ITERS = MAC_MIN_WIDTH/BITS_PER_CYCLE cycles from the accept edge to out_valid.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module mac_seq_multiply #(
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAC_MIN_WIDTH-1:0]  A,
    input  logic [MAC_MIN_WIDTH-1:0]  B,
    input  logic                      is_signed,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [MAC_MULT_WIDTH-1:0] C,
    output logic                      busy
);

    localparam int N     = MAC_MIN_WIDTH;
    localparam int W     = MAC_MULT_WIDTH;
    localparam int K     = BITS_PER_CYCLE;
    localparam int ITERS = N / K;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic             neg;
    logic [W-1:0]     acc;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [W-1:0]     digit_prod;
    logic [W-1:0]     acc_next;

    // Handshake status comes straight from the state register, never from inputs.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Operand magnitudes; the most negative value negates onto itself, which is
    // exactly 2^(N-1) when read as unsigned.
    always_comb begin
        a_mag = (is_signed && A[N-1]) ? -A : A;
        b_mag = (is_signed && B[N-1]) ? -B : B;
    end

    // One radix-2^K partial product, aligned to its digit position and accumulated.
    always_comb begin
        digit_prod = W'(mcand) * W'(mplier[K-1:0]);
        acc_next   = acc + (digit_prod << (int'(cnt) * K));
    end

    // Control FSM and datapath registers; the sign is reapplied once on the last RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            C         <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (A[N-1] ^ B[N-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> K;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(ITERS - 1)) begin
                        C         <= neg ? -acc_next : acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_seq_multiply.sv
// Bench for mac_seq_multiply: four instances with N=8 and K = 1, 2, 4, 8.
// Directed scenarios run on the K=2 instance; the sweep and random traffic use all four.
// Random results are checked against plain integer multiplication.
module tb_mac_seq_multiply;

    localparam int NT = 2500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic        sgn       [4];
    logic [7:0]  a_in      [4];
    logic [7:0]  b_in      [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic        busy      [4];
    logic [15:0] c_out     [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_seq_multiply #(
            .MAC_MIN_WIDTH (8),
            .MAC_MULT_WIDTH(16),
            .BITS_PER_CYCLE(1 << g)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .A        (a_in[g]),
            .B        (b_in[g]),
            .is_signed(sgn[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .C        (c_out[g]),
            .busy     (busy[g])
        );
    end

    // Reference product: mathematical product of the operands as integers, low 16 bits.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
        int pa;
        int pb;
        int p;
        if (s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        p = pa * pb;
        return p[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one operand pair, then count cycles until out_valid; reports whether in_ready stayed low.
    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s,
                          output int lat, output logic [15:0] c, output bit ready_low);
        int guard;
        guard = 0;
        while (!in_ready[i] && guard < 50) begin
            tick();
            guard++;
        end
        a_in[i] = a;
        b_in[i] = b;
        sgn[i] = s;
        in_valid[i] = 1'b1;
        tick();
        in_valid[i] = 1'b0;
        a_in[i] = 8'h5A;
        b_in[i] = 8'hA5;
        sgn[i] = ~s;
        lat = 0;
        ready_low = 1'b1;
        while (!out_valid[i] && lat < 40) begin
            if (in_ready[i]) ready_low = 1'b0;
            tick();
            lat++;
        end
        if (in_ready[i]) ready_low = 1'b0;
        c = c_out[i];
    endtask

    task automatic drain(input int i);
        out_ready[i] = 1'b1;
        tick();
        out_ready[i] = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp += 4;
            if (in_ready[i] !== 1'b1) begin n_err++; $display("FAIL reset_in_ready[%0d] got %b want 1", i, in_ready[i]); end
            if (out_valid[i] !== 1'b0) begin n_err++; $display("FAIL reset_out_valid[%0d] got %b want 0", i, out_valid[i]); end
            if (busy[i] !== 1'b0) begin n_err++; $display("FAIL reset_busy[%0d] got %b want 0", i, busy[i]); end
            if (c_out[i] !== 16'h0000) begin n_err++; $display("FAIL reset_c[%0d] got %h want 0000", i, c_out[i]); end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unsigned_max();
        int lat;
        logic [15:0] c;
        bit rl;
        run_op(1, 8'hFF, 8'hFF, 1'b0, lat, c, rl);
        n_cmp += 3;
        if (c !== 16'hFE01) begin n_err++; $display("FAIL umax_c got %h want fe01", c); end
        if (lat !== 4) begin n_err++; $display("FAIL umax_latency got %0d want 4", lat); end
        if (rl !== 1'b1) begin n_err++; $display("FAIL umax_in_ready_low got %b want 1", rl); end
        drain(1);
        n_cmp += 2;
        if (in_ready[1] !== 1'b1) begin n_err++; $display("FAIL umax_idle_in_ready got %b want 1", in_ready[1]); end
        if (out_valid[1] !== 1'b0) begin n_err++; $display("FAIL umax_idle_out_valid got %b want 0", out_valid[1]); end
    endtask

    task automatic test_sign_modes();
        logic [7:0]  ta [4] = '{8'hFF, 8'hFF, 8'h80, 8'h80};
        logic [7:0]  tb [4] = '{8'h02, 8'h02, 8'h80, 8'h7F};
        logic        ts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [15:0] te [4] = '{16'hFFFE, 16'h01FE, 16'h4000, 16'hC080};
        int lat;
        logic [15:0] c;
        bit rl;
        for (int k = 0; k < 4; k++) begin
            run_op(1, ta[k], tb[k], ts[k], lat, c, rl);
            n_cmp++;
            if (c !== te[k]) begin
                n_err++;
                $display("FAIL sign_mode[%0d] %h*%h s=%b got %h want %h", k, ta[k], tb[k], ts[k], c, te[k]);
            end
            drain(1);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] c;
        bit rl;
        run_op(1, 8'h21, 8'h03, 1'b0, lat, c, rl);
        n_cmp++;
        if (c !== 16'h0063) begin n_err++; $display("FAIL bp_first_c got %h want 0063", c); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_valid[1] = cyc[0];
            a_in[1] = 8'h11;
            b_in[1] = 8'h11;
            tick();
            n_cmp++;
            if (out_valid[1] !== 1'b1 || c_out[1] !== 16'h0063 || in_ready[1] !== 1'b0 || busy[1] !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got ov=%b c=%h rdy=%b busy=%b want ov=1 c=0063 rdy=0 busy=1",
                         cyc, out_valid[1], c_out[1], in_ready[1], busy[1]);
            end
        end
        in_valid[1] = 1'b0;
        drain(1);
        n_cmp++;
        if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release got rdy=%b ov=%b want rdy=1 ov=0", in_ready[1], out_valid[1]);
        end
        run_op(1, 8'h03, 8'h05, 1'b0, lat, c, rl);
        n_cmp += 2;
        if (c !== 16'h000F) begin n_err++; $display("FAIL bp_next_c got %h want 000f", c); end
        if (lat !== 4) begin n_err++; $display("FAIL bp_next_latency got %0d want 4", lat); end
        drain(1);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [15:0] c;
        bit rl;
        a_in[1] = 8'h7F;
        b_in[1] = 8'h7F;
        sgn[1] = 1'b0;
        in_valid[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid[1] !== 1'b0 || c_out[1] !== 16'h0000 || in_ready[1] !== 1'b1 || busy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_run got ov=%b c=%h rdy=%b busy=%b want ov=0 c=0000 rdy=1 busy=0",
                     out_valid[1], c_out[1], in_ready[1], busy[1]);
        end
        in_valid[1] = 1'b1;
        a_in[1] = 8'h11;
        tick();
        tick();
        n_cmp++;
        if (busy[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rst_no_accept got busy=%b rdy=%b want busy=0 rdy=1", busy[1], in_ready[1]);
        end
        in_valid[1] = 1'b0;
        rst_n = 1'b1;
        tick();
        run_op(1, 8'h0A, 8'h0C, 1'b0, lat, c, rl);
        n_cmp += 2;
        if (c !== 16'h0078) begin n_err++; $display("FAIL rst_after_c got %h want 0078", c); end
        if (lat !== 4) begin n_err++; $display("FAIL rst_after_latency got %0d want 4", lat); end
        drain(1);
    endtask

    task automatic test_zero();
        int lat;
        logic [15:0] c;
        bit rl;
        run_op(1, 8'h00, 8'hFF, 1'b1, lat, c, rl);
        n_cmp += 2;
        if (c !== 16'h0000) begin n_err++; $display("FAIL zero_c got %h want 0000", c); end
        if (lat !== 4) begin n_err++; $display("FAIL zero_latency got %0d want 4", lat); end
        drain(1);
    endtask

    task automatic test_sweep();
        int lat;
        logic [15:0] c;
        bit rl;
        for (int i = 0; i < 4; i++) begin
            run_op(i, 8'hFF, 8'hFF, 1'b0, lat, c, rl);
            n_cmp += 2;
            if (lat !== (8 >> i)) begin n_err++; $display("FAIL sweep_latency K=%0d got %0d want %0d", 1 << i, lat, 8 >> i); end
            if (c !== 16'hFE01) begin n_err++; $display("FAIL sweep_umax K=%0d got %h want fe01", 1 << i, c); end
            drain(i);
            run_op(i, 8'h80, 8'h7F, 1'b1, lat, c, rl);
            n_cmp += 2;
            if (lat !== (8 >> i)) begin n_err++; $display("FAIL sweep_s_latency K=%0d got %0d want %0d", 1 << i, lat, 8 >> i); end
            if (c !== 16'hC080) begin n_err++; $display("FAIL sweep_smin K=%0d got %h want c080", 1 << i, c); end
            drain(i);
        end
    endtask

    // Random traffic with stalls on both sides; accepted operands queue their expected product.
    task automatic run_random(input int i, input int nt);
        logic [15:0] q[$];
        int acc_cnt;
        int cyc;
        logic [7:0] a;
        logic [7:0] b;
        logic s;
        acc_cnt = 0;
        cyc = 0;
        while ((acc_cnt < nt || q.size() > 0) && cyc < nt * 40) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            a_in[i] = a;
            b_in[i] = b;
            sgn[i] = s;
            in_valid[i] = (acc_cnt < nt) && ($urandom_range(0, 1) == 1);
            out_ready[i] = ($urandom_range(0, 2) != 0);
            if (in_valid[i] && in_ready[i]) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_err++;
                    $display("FAIL rand_overlap K=%0d accepted with %0d result(s) pending, want 0", 1 << i, q.size());
                end
                q.push_back(ref_mul(a, b, s));
                acc_cnt++;
            end
            if (out_valid[i] && out_ready[i]) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_spurious K=%0d out_valid with c=%h, want no result", 1 << i, c_out[i]);
                end else begin
                    if (c_out[i] !== q[0]) begin
                        n_err++;
                        $display("FAIL rand_product K=%0d got %h want %h", 1 << i, c_out[i], q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            tick();
            cyc++;
        end
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b0;
        n_cmp++;
        if (acc_cnt != nt || q.size() != 0) begin
            n_err++;
            $display("FAIL rand_timeout K=%0d got %0d accepted, %0d pending want %0d accepted, 0 pending",
                     1 << i, acc_cnt, q.size(), nt);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b0;
            sgn[i] = 1'b0;
            a_in[i] = 8'h00;
            b_in[i] = 8'h00;
        end
        test_reset();
        test_unsigned_max();
        test_sign_modes();
        test_backpressure();
        test_reset_mid_run();
        test_zero();
        test_sweep();
        fork
            run_random(0, NT);
            run_random(1, NT);
            run_random(2, NT);
            run_random(3, NT);
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
